// File: rtl/nfca_tx_modulate_if.sv
// Bit-strobe and modulation handshake between nfca_tx_frame, nfca_tx_modulate and the RF front-end.
// The slave modport is the modulator; the master side is the frame source and pause observer.
interface nfca_tx_modulate_if;
    logic tx_req;
    logic tx_en;
    logic tx_bit;
    logic carrier_on;
    logic tx_busy;
    logic tx_done;

    modport master (
        input  tx_req,
        input  carrier_on,
        input  tx_busy,
        input  tx_done,
        output tx_en,
        output tx_bit
    );

    modport slave (
        output tx_req,
        output carrier_on,
        output tx_busy,
        output tx_done,
        input  tx_en,
        input  tx_bit
    );
endinterface

// File: rtl/nfca_tx_modulate.sv
// ISO14443-A PCD->PICC bit timing and modified-Miller (X/Y/Z) encoder.
// Samples tx_en/tx_bit at the last phase of each bit period and emits the symbol during the next one.
module nfca_tx_modulate #(
    parameter int unsigned BIT_LEN   = 768,
    parameter int unsigned PAUSE_LEN = 192
) (
    input  logic              rstn,
    input  logic              clk,
    nfca_tx_modulate_if.slave bus
);

    localparam int unsigned     PH_W    = $clog2(BIT_LEN);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(BIT_LEN - 1);
    localparam logic [PH_W-1:0] Z_END   = PH_W'(PAUSE_LEN);
    localparam logic [PH_W-1:0] X_START = PH_W'(BIT_LEN / 2);
    localparam logic [PH_W-1:0] X_END   = PH_W'(BIT_LEN / 2 + PAUSE_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_TAIL
    } state_t;

    typedef enum logic [1:0] {
        SYM_X,
        SYM_Y,
        SYM_Z
    } sym_t;

    logic [PH_W-1:0] ph;
    state_t          state;
    state_t          state_nxt;
    sym_t            sym;
    sym_t            sym_nxt;
    logic            prev0;
    logic            prev0_nxt;
    logic            done_nxt;
    logic            sample;
    logic            pause;
    logic            tx_req_q;
    logic            carrier_q;
    logic            tx_done_q;

    assign sample = (ph == PH_LAST);

    // Pause windows are decoded from the current ph; the carrier register adds the one-cycle offset.
    always_comb begin
        pause = 1'b0;
        case (sym)
            SYM_Z:   pause = (ph < Z_END);
            SYM_X:   pause = (ph >= X_START) && (ph < X_END);
            default: pause = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sym_nxt   = sym;
        prev0_nxt = prev0;
        done_nxt  = 1'b0;
        if (sample) begin
            case (state)
                ST_IDLE: begin
                    if (bus.tx_en) begin
                        sym_nxt   = SYM_Z;
                        prev0_nxt = 1'b1;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        sym_nxt = SYM_Y;
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.tx_en) begin
                        sym_nxt   = SYM_Y;
                        state_nxt = ST_TAIL;
                    end else if (bus.tx_bit) begin
                        sym_nxt   = SYM_X;
                        prev0_nxt = 1'b0;
                    end else begin
                        sym_nxt   = prev0 ? SYM_Z : SYM_Y;
                        prev0_nxt = 1'b1;
                    end
                end
                ST_TAIL: begin
                    // Trailer ends here; the same sample may already start the next frame.
                    done_nxt = 1'b1;
                    if (bus.tx_en) begin
                        sym_nxt   = SYM_Z;
                        prev0_nxt = 1'b1;
                        state_nxt = ST_ACTIVE;
                    end else begin
                        sym_nxt   = SYM_Y;
                        prev0_nxt = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    sym_nxt   = SYM_Y;
                    prev0_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph        <= '0;
            state     <= ST_IDLE;
            sym       <= SYM_Y;
            prev0     <= 1'b0;
            tx_req_q  <= 1'b0;
            carrier_q <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            ph        <= sample ? '0 : ph + 1'b1;
            state     <= state_nxt;
            sym       <= sym_nxt;
            prev0     <= prev0_nxt;
            tx_req_q  <= sample;
            carrier_q <= ~pause;
            tx_done_q <= done_nxt;
        end
    end

    assign bus.tx_req     = tx_req_q;
    assign bus.carrier_on = carrier_q;
    assign bus.tx_busy    = (state != ST_IDLE);
    assign bus.tx_done    = tx_done_q;

endmodule

// File: tb/tb_nfca_tx_modulate.sv
// Directed bench for nfca_tx_modulate: two instances (192- and 64-cycle pauses) share one stimulus.
// Each bit period is checked for strobe position, busy/done levels and the exact pause window.
`timescale 1ns/1ps
module tb_nfca_tx_modulate;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nfca_tx_modulate_if bus_a ();
    nfca_tx_modulate_if bus_b ();

    nfca_tx_modulate #(.BIT_LEN(768), .PAUSE_LEN(192)) dut_a (
        .rstn (rstn),
        .clk  (clk),
        .bus  (bus_a.slave)
    );

    nfca_tx_modulate #(.BIT_LEN(768), .PAUSE_LEN(64)) dut_b (
        .rstn (rstn),
        .clk  (clk),
        .bus  (bus_b.slave)
    );

    int errors = 0;
    int checks = 0;
    int pidx   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL p%0d %s: observed=%0d expected=%0d", pidx, tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL p%0d %s: observed=%b expected=%b", pidx, tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic b);
        bus_a.tx_en  = en;
        bus_a.tx_bit = b;
        bus_b.tx_en  = en;
        bus_b.tx_bit = b;
    endtask

    // Runs ncyc cycles starting at the ph==0 negedge; drives the next slot's inputs at ph==1.
    task automatic period(input logic en, input logic b, input byte sym, input logic busy,
                          input logic done, input logic first, input int ncyc);
        int lo_a = 0, fa = -1, la = -1;
        int lo_b = 0, fb = -1, lb = -1;
        int bad_req = 0, bad_done = 0, bad_busy = 0;
        pidx++;
        for (int p = 0; p < ncyc; p++) begin
            if (p == 0) begin
                chk1("req_a@ph0", bus_a.tx_req, !first);
                chk1("req_b@ph0", bus_b.tx_req, !first);
                chk1("done_a@ph0", bus_a.tx_done, done);
                chk1("done_b@ph0", bus_b.tx_done, done);
            end else begin
                if (bus_a.tx_req !== 1'b0 || bus_b.tx_req !== 1'b0) bad_req++;
                if (bus_a.tx_done !== 1'b0 || bus_b.tx_done !== 1'b0) bad_done++;
            end
            if (bus_a.tx_busy !== busy || bus_b.tx_busy !== busy) bad_busy++;
            if (bus_a.carrier_on !== 1'b1) begin
                lo_a++;
                if (fa < 0) fa = p;
                la = p;
            end
            if (bus_b.carrier_on !== 1'b1) begin
                lo_b++;
                if (fb < 0) fb = p;
                lb = p;
            end
            if (p == 1) drive(en, b);
            @(negedge clk);
        end
        chk("stray_req", bad_req, 0);
        chk("stray_done", bad_done, 0);
        chk("busy_cycles_wrong", bad_busy, 0);
        if (ncyc == 768) begin
            case (sym)
                "Z": begin
                    chk("z_len_a", lo_a, 192);  chk("z_first_a", fa, 1);   chk("z_last_a", la, 192);
                    chk("z_len_b", lo_b, 64);   chk("z_first_b", fb, 1);   chk("z_last_b", lb, 64);
                end
                "X": begin
                    chk("x_len_a", lo_a, 192);  chk("x_first_a", fa, 385); chk("x_last_a", la, 576);
                    chk("x_len_b", lo_b, 64);   chk("x_first_b", fb, 385); chk("x_last_b", lb, 448);
                end
                default: begin
                    chk("y_low_a", lo_a, 0);
                    chk("y_low_b", lo_b, 0);
                end
            endcase
        end
    endtask

    initial begin
        drive(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk1("rst_carrier_a", bus_a.carrier_on, 1'b1);
        chk1("rst_busy_a", bus_a.tx_busy, 1'b0);
        chk1("rst_req_a", bus_a.tx_req, 1'b0);
        chk1("rst_done_a", bus_a.tx_done, 1'b0);
        rstn = 1'b1;

        // Idle: ten periods, carrier untouched, strobe every 768 cycles starting at cycle 768.
        period(1'b0, 1'b0, "Y", 1'b0, 1'b0, 1'b1, 768);
        for (int i = 0; i < 9; i++) period(1'b0, 1'b0, "Y", 1'b0, 1'b0, 1'b0, 768);

        // REQA: S,0,1,1,0,0,1,0,E -> Z,Z,X,X,Y,Z,X,Y,Z then trailer Y.
        period(1'b1, 1'b1, "Y", 1'b0, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "X", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "X", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "Y", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "X", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "Y", 1'b1, 1'b0, 1'b0, 768);
        period(1'b0, 1'b0, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b0, 1'b0, "Y", 1'b1, 1'b0, 1'b0, 768);
        period(1'b0, 1'b0, "Y", 1'b0, 1'b1, 1'b0, 768);

        // S,1,0,0,0 -> Z,X,Y,Z,Z,Y; tx_bit=1 with tx_en=0 is ignored; new frame starts inside the trailer.
        period(1'b1, 1'b0, "Y", 1'b0, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "X", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "Y", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b0, 1'b1, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "Y", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "Z", 1'b1, 1'b1, 1'b0, 768);
        period(1'b0, 1'b0, "X", 1'b1, 1'b0, 1'b0, 768);
        period(1'b0, 1'b0, "Y", 1'b1, 1'b0, 1'b0, 768);
        period(1'b0, 1'b0, "Y", 1'b0, 1'b1, 1'b0, 768);

        // Reset at ph=200 of an X period.
        period(1'b1, 1'b1, "Y", 1'b0, 1'b0, 1'b0, 768);
        period(1'b1, 1'b1, "Z", 1'b1, 1'b0, 1'b0, 768);
        period(1'b1, 1'b0, "X", 1'b1, 1'b0, 1'b0, 200);
        rstn = 1'b0;
        #1;
        chk1("rstX_carrier_a", bus_a.carrier_on, 1'b1);
        chk1("rstX_carrier_b", bus_b.carrier_on, 1'b1);
        chk1("rstX_busy_a", bus_a.tx_busy, 1'b0);
        chk1("rstX_busy_b", bus_b.tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0);
        rstn = 1'b1;
        period(1'b1, 1'b0, "Y", 1'b0, 1'b0, 1'b1, 768);
        period(1'b1, 1'b0, "Z", 1'b1, 1'b0, 1'b0, 768);

        // Reset at ph=100 while the Z pause of dut_a is in progress.
        period(1'b1, 1'b0, "Z", 1'b1, 1'b0, 1'b0, 100);
        chk1("preZ_carrier_a", bus_a.carrier_on, 1'b0);
        chk1("preZ_carrier_b", bus_b.carrier_on, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("rstZ_carrier_a", bus_a.carrier_on, 1'b1);
        chk1("rstZ_busy_a", bus_a.tx_busy, 1'b0);
        chk1("rstZ_req_a", bus_a.tx_req, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0);
        rstn = 1'b1;
        period(1'b0, 1'b0, "Y", 1'b0, 1'b0, 1'b1, 768);
        period(1'b0, 1'b0, "Y", 1'b0, 1'b0, 1'b0, 768);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nfca_tx_modulate.md
Name: nfca_tx_modulate

Overview:
- Bit-timing and modified-Miller encoder for the PCD→PICC direction, directly downstream of nfca_tx_frame inside nfca_controller.
- Generates the periodic tx_req bit strobe, samples tx_en/tx_bit, and encodes each bit as an ISO14443-A sequence X, Y or Z.
- Drives carrier_on, the 100% ASK pause control, to the RF front-end.
- Runs at 81.36 MHz, which is 6x the 13.56 MHz carrier. One bit is 128/fc, or 768 clk.

Parameters:
- BIT_LEN, 768: clk cycles per bit period. Must be even, ≥ 8.
- PAUSE_LEN, 192: clk cycles per pause (32/fc ≈ 2.36 µs). Range 1..BIT_LEN/2-1.

Ports:
- rstn  input  1  Asynchronous reset, active-low. 0 = reset, 1 = work.
- clk  input  1  Single clock, 81.36 MHz.
- tx_req  output  1  One-cycle bit strobe to nfca_tx_frame.
- tx_en  input  1  From nfca_tx_frame. 1 = a bit is being sent in this slot.
- tx_bit  input  1  From nfca_tx_frame. Bit value for this slot.
- carrier_on  output  1  1 = carrier on, 0 = pause (modulate).
- tx_busy  output  1  1 while a frame (including its trailing Y) is on air.
- tx_done  output  1  One-cycle pulse at the end of the trailing Y.

Behaviour:
- Reset values (rstn=0, asynchronous): ph=0, state=IDLE, sym=Y, prev0=0, tx_req=0, carrier_on=1, tx_busy=0, tx_done=0.
  - Reset mid-frame takes effect immediately: carrier restored and frame abandoned.
- Phase counter ph:
  - Free-running, 0..BIT_LEN-1, wraps to 0.
  - tx_req <= (ph==BIT_LEN-1), so tx_req is high during every cycle with ph==0, except the cycle of reset release.
  - First tx_req pulse is BIT_LEN cycles after rstn rises. Pulses are never suppressed, including when idle (nfca_tx_frame needs them to return to ready).
- Sampling:
  - nfca_tx_frame updates tx_en/tx_bit one cycle after tx_req. Both are stable from ph==1.
  - Sample at ph==BIT_LEN-1. The resulting symbol is emitted during the next bit period.
  - Latency: request in period k → on air in period k+1.
- Symbol shapes, within a period (ph referenced):
  - Z: pause for ph in [0, PAUSE_LEN).
  - X: pause for ph in [BIT_LEN/2, BIT_LEN/2+PAUSE_LEN).
  - Y: no pause.
  - carrier_on is registered. Each pause is exactly PAUSE_LEN consecutive cycles, starting 1 clk after ph enters the window.
- State machine, evaluated at each sample point:
  - IDLE:
    - tx_en=1 → sym=Z (start of communication; this bit is nfca_tx_frame's S bit, value ignored), prev0=1, → ACTIVE.
    - Else sym=Y, stay.
  - ACTIVE, tx_en=1:
    - tx_bit=1 → sym=X, prev0=0.
    - tx_bit=0 → sym = prev0 ? Z : Y, prev0=1.
    - The E bit from nfca_tx_frame is an ordinary 0 under these rules.
  - ACTIVE, tx_en=0 → sym=Y (end-of-communication trailer), → TAIL.
  - TAIL:
    - tx_done=1 for this one cycle, prev0=0.
    - Then apply the IDLE rule to the current sample: a back-to-back frame start gives Z and → ACTIVE. Otherwise → IDLE.
- tx_busy: 1 from the cycle the IDLE→ACTIVE sample is taken until the TAIL exit sample. It is 1 whenever state≠IDLE.
- tx_bit is ignored whenever tx_en=0.
- No other inputs affect timing. Modulation can never start mid-period.

Test Plan:
1. Reset, tx_en held 0 for 10 periods → carrier_on=1 throughout; tx_req pulses exactly every 768 clk, first at clk 768 after release; tx_busy=0, tx_done=0.
2. Drive with nfca_tx_frame loaded with REQA 0x26 (7 bits) → on-air bits S,0,1,1,0,0,1,0,E encode as Z,Z,X,X,Y,Z,X,Y,Z, then trailer Y; tx_done pulses once at the end of Y; tx_busy spans 10 periods.
3. Measure pauses in scenario 2 → every low pulse is exactly 192 clk. Z pause starts 1 clk after ph=0; X pause starts 1 clk after ph=384; no pause in Y periods.
4. Bit stream S,1,0,0,0 then tx_en=0 → Z,X,Y,Z,Z,Y. Confirms that a 0 after a 1 gives Y and a run of 0s gives Z.
5. Assert rstn=0 at ph=200 of an X period in mid-frame → carrier_on=1 and tx_busy=0 in the same cycle; after release, no tx_req for 768 clk, and the next frame starts with Z.
6. Override BIT_LEN=768, PAUSE_LEN=64, repeat scenario 2 → identical symbol sequence with 64-clk pauses; X pause at ph 384..447.
